eth_tx_stream_sink: RTL and testbench

- Far-end consumer of the 32-bit stb/ack ethernet TX stream produced by the software cores.
- Takes a length word followed by packed 16-bit payload words and serialises them as a byte stream with valid/ready and last flags, toward the MAC/PHY transmit logic.
- Enforces an inter-frame gap after each frame.
- Rejects and discards malformed frames so stream framing stays aligned.

---
 rtl/eth_tx_stream_sink_if.sv | 29 ++
 rtl/eth_tx_stream_sink.sv | 147 ++++++++++++++
 tb/tb_eth_tx_stream_sink.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_stream_sink_if.sv
// Bundles the 32-bit stb/ack word stream, the byte-wide valid/ready TX stream,
// the frame status pulses and the FSM debug view into one port.
interface eth_tx_stream_sink_if;
  // Input words move on a clock edge where input_eth_tx_stb && input_eth_tx_ack.
  // Bytes move on a clock edge where tx_valid && tx_ready. Once raised, tx_valid
  // and its data/last hold until that edge.
  logic [31:0] input_eth_tx;
  logic        input_eth_tx_stb;
  logic        input_eth_tx_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        frame_done;
  logic        frame_error;
  logic [2:0]  fsm_state;

  modport master (
    output input_eth_tx, input_eth_tx_stb, tx_ready,
    input  input_eth_tx_ack, tx_data, tx_valid, tx_last,
           frame_done, frame_error, fsm_state
  );

  modport slave (
    input  input_eth_tx, input_eth_tx_stb, tx_ready,
    output input_eth_tx_ack, tx_data, tx_valid, tx_last,
           frame_done, frame_error, fsm_state
  );
endinterface

// File: rtl/eth_tx_stream_sink.sv
// Turns length-prefixed 16-bit stream words into a framed byte stream,
// discarding malformed frames and holding an inter-frame gap after each one.
module eth_tx_stream_sink #(
  parameter int MAX_BYTES  = 1514,
  parameter int IFG_CYCLES = 12
) (
  input logic clk,
  input logic rst,
  eth_tx_stream_sink_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HI      = 3'd2,
    S_LO      = 3'd3,
    S_DONE    = 3'd4,
    S_DISCARD = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  localparam logic [15:0] MAX_LEN  = 16'(MAX_BYTES);
  localparam logic [15:0] GAP_LOAD = 16'(IFG_CYCLES);

  state_t      state, state_n;
  logic [15:0] rem, rem_n;
  logic [15:0] word, word_n;
  logic [15:0] gap_cnt, gap_n;
  logic [16:0] wcnt, wcnt_n;
  logic        ack, ack_n;
  logic        err, err_n;
  logic        in_xfer;
  logic [15:0] len;
  logic [16:0] len_words;
  logic        unused_hi_bits;

  assign len            = bus.input_eth_tx[15:0];
  assign unused_hi_bits = ^bus.input_eth_tx[31:16];
  // 17 bits so a length of 0xFFFF rounds up to 32768 words.
  assign len_words      = ({1'b0, len} + 17'd1) >> 1;
  assign in_xfer        = bus.input_eth_tx_stb && ack;

  assign bus.input_eth_tx_ack = ack;
  assign bus.frame_error      = err;
  assign bus.fsm_state        = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rem     <= '0;
      word    <= '0;
      gap_cnt <= '0;
      wcnt    <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      word    <= word_n;
      gap_cnt <= gap_n;
      wcnt    <= wcnt_n;
      ack     <= ack_n;
      err     <= err_n;
    end
  end

  always_comb begin
    state_n        = state;
    rem_n          = rem;
    word_n         = word;
    gap_n          = gap_cnt;
    wcnt_n         = wcnt;
    err_n          = 1'b0;
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.tx_last    = 1'b0;
    bus.frame_done = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_xfer) begin
          if (len == 16'd0) begin
            err_n   = 1'b1;
            gap_n   = GAP_LOAD;
            state_n = S_GAP;
          end else if (len > MAX_LEN) begin
            err_n   = 1'b1;
            wcnt_n  = len_words;
            state_n = S_DISCARD;
          end else begin
            rem_n   = len;
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_xfer) begin
          word_n  = bus.input_eth_tx[15:0];
          state_n = S_HI;
        end
      end
      S_HI: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = word[15:8];
        bus.tx_last  = (rem == 16'd1);
        if (bus.tx_ready) begin
          rem_n   = rem - 16'd1;
          state_n = (rem == 16'd1) ? S_DONE : S_LO;
        end
      end
      S_LO: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = word[7:0];
        bus.tx_last  = (rem == 16'd1);
        if (bus.tx_ready) begin
          rem_n   = rem - 16'd1;
          state_n = (rem == 16'd1) ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        bus.frame_done = 1'b1;
        gap_n          = GAP_LOAD;
        state_n        = S_GAP;
      end
      S_DISCARD: begin
        if (in_xfer) begin
          wcnt_n = wcnt - 17'd1;
          if (wcnt == 17'd1) begin
            gap_n   = GAP_LOAD;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        // A zero gap still spends one cycle here.
        if (gap_cnt <= 16'd1) state_n = S_IDLE;
        else                  gap_n   = gap_cnt - 16'd1;
      end
      default: state_n = S_IDLE;
    endcase

    // Registered ack: raised entering an accept state, dropped on the accepting edge.
    ack_n = ((state_n == S_IDLE) || (state_n == S_LOAD) || (state_n == S_DISCARD))
            && !in_xfer;
  end

endmodule

// File: tb/tb_eth_tx_stream_sink.sv
// Directed bench for eth_tx_stream_sink: framing, odd lengths, backpressure,
// error/discard paths, inter-frame gap and mid-frame reset.
module tb_eth_tx_stream_sink;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eth_tx_stream_sink_if bus();

  eth_tx_stream_sink #(.MAX_BYTES(1514), .IFG_CYCLES(12)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic       valid_seen = 1'b0;
  logic [8:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.tx_valid === 1'b1) valid_seen = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    int t;
    bus.input_eth_tx     = {16'($urandom), w};
    bus.input_eth_tx_stb = 1'b1;
    t = 0;
    while (bus.input_eth_tx_ack !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("ack_timeout", {31'd0, bus.input_eth_tx_ack}, 32'd1);
    tick();
    bus.input_eth_tx_stb = 1'b0;
    bus.input_eth_tx     = '0;
  endtask

  task automatic recv_byte();
    logic [8:0] e;
    int t;
    if (exp_q.size() == 0) begin
      check("exp_q_underflow", exp_q.size(), 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    bus.tx_ready = 1'b1;
    t = 0;
    while (bus.tx_valid !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    check("byte_valid", {31'd0, bus.tx_valid}, 32'd1);
    check("byte_data",  {24'd0, bus.tx_data}, {24'd0, e[7:0]});
    check("byte_last",  {31'd0, bus.tx_last}, {31'd0, e[8]});
    tick();
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    int nx;
    int t;
    logic       rdy_v [5];
    logic [7:0] dat_v [5];
    logic       lst_v [5];

    bus.input_eth_tx     = '0;
    bus.input_eth_tx_stb = 1'b0;
    bus.tx_ready         = 1'b0;

    // Reset values
    #1;
    check("rst_ack",   {31'd0, bus.input_eth_tx_ack}, 32'd0);
    check("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_last",  {31'd0, bus.tx_last}, 32'd0);
    check("rst_done",  {31'd0, bus.frame_done}, 32'd0);
    check("rst_err",   {31'd0, bus.frame_error}, 32'd0);
    check("rst_data",  {24'd0, bus.tx_data}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // L=4: 11 22 33 44, then a 12-cycle gap with ack low
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33});
    exp_q.push_back({1'b1, 8'h44});
    send_word(16'd4);
    send_word(16'h1122);
    recv_byte();
    recv_byte();
    send_word(16'h3344);
    recv_byte();
    recv_byte();
    check("t1_frame_done", {31'd0, bus.frame_done}, 32'd1);
    cnt = 0;
    repeat (12) begin
      tick();
      if (bus.input_eth_tx_ack === 1'b1) cnt++;
    end
    check("t1_gap_ack_high_cycles", cnt, 32'd0);
    tick();
    check("t1_ack_after_gap", {31'd0, bus.input_eth_tx_ack}, 32'd1);

    // L=3: odd length drops the low byte of the last word; then L=2
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hBB});
    exp_q.push_back({1'b1, 8'h55});
    send_word(16'd3);
    send_word(16'hAABB);
    recv_byte();
    recv_byte();
    send_word(16'h55CC);
    recv_byte();
    check("t2_frame_done", {31'd0, bus.frame_done}, 32'd1);
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    send_word(16'd2);
    send_word(16'h0102);
    recv_byte();
    recv_byte();
    check("t2b_frame_done", {31'd0, bus.frame_done}, 32'd1);

    // Backpressure: tx_ready 0,0,1,0,1 over a 2-byte frame
    send_word(16'd2);
    send_word(16'hDEAD);
    rdy_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    dat_v = '{8'hDE, 8'hDE, 8'hDE, 8'hAD, 8'hAD};
    lst_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nx = 0;
    for (int i = 0; i < 5; i++) begin
      bus.tx_ready = rdy_v[i];
      check("t3_valid", {31'd0, bus.tx_valid}, 32'd1);
      check("t3_data",  {24'd0, bus.tx_data}, {24'd0, dat_v[i]});
      check("t3_last",  {31'd0, bus.tx_last}, {31'd0, lst_v[i]});
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) nx++;
      tick();
    end
    bus.tx_ready = 1'b0;
    check("t3_byte_xfers", nx, 32'd2);
    check("t3_frame_done", {31'd0, bus.frame_done}, 32'd1);

    // L=0: error pulse, no bytes, ack back after gap; then L=1
    send_word(16'd0);
    valid_seen = 1'b0;
    check("t4_err_pulse", {31'd0, bus.frame_error}, 32'd1);
    tick();
    check("t4_err_one_cycle", {31'd0, bus.frame_error}, 32'd0);
    t = 0;
    while (bus.input_eth_tx_ack !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    check("t4_ack_returns", {31'd0, bus.input_eth_tx_ack}, 32'd1);
    check("t4_no_valid", {31'd0, valid_seen}, 32'd0);
    exp_q.push_back({1'b1, 8'h7F});
    send_word(16'd1);
    send_word(16'h7F00);
    recv_byte();
    check("t4_frame_done", {31'd0, bus.frame_done}, 32'd1);

    // L=1600 exceeds MAX_BYTES: 800 words swallowed, then a good frame
    send_word(16'd1600);
    valid_seen = 1'b0;
    check("t5_err_pulse", {31'd0, bus.frame_error}, 32'd1);
    for (int i = 0; i < 800; i++) send_word(16'($urandom));
    check("t5_state_gap", {29'd0, bus.fsm_state}, 32'd6);
    check("t5_ack_low", {31'd0, bus.input_eth_tx_ack}, 32'd0);
    check("t5_no_valid", {31'd0, valid_seen}, 32'd0);
    exp_q.push_back({1'b0, 8'hBE});
    exp_q.push_back({1'b1, 8'hEF});
    send_word(16'd2);
    send_word(16'hBEEF);
    recv_byte();
    recv_byte();
    check("t5_frame_done", {31'd0, bus.frame_done}, 32'd1);

    // Reset while in LO of an L=6 frame
    exp_q.push_back({1'b0, 8'h0A});
    send_word(16'd6);
    send_word(16'h0A0B);
    recv_byte();
    check("t6_in_lo", {29'd0, bus.fsm_state}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("t6_rst_ack",   {31'd0, bus.input_eth_tx_ack}, 32'd0);
    check("t6_rst_last",  {31'd0, bus.tx_last}, 32'd0);
    check("t6_rst_state", {29'd0, bus.fsm_state}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b1, 8'hDE});
    send_word(16'd2);
    send_word(16'hC0DE);
    recv_byte();
    recv_byte();
    check("t6_frame_done", {31'd0, bus.frame_done}, 32'd1);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
